jcb_nway: RTL

Parametrised, clocked successor to the two-input Josephson confluence buffer model. It merges N single-pulse input channels onto one output pulse line. An input pulse is rejected if any other channel pulsed within a guard window. Each accepted pulse reappears on `dout` after a fixed latency with a programmable width. Simultaneous arrivals are either all dropped or resolved by fixed priority, and the block keeps saturating accept/drop statistics for the pulse-logic test harness.

---
 rtl/jcb_nway.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/jcb_nway.sv
`timescale 1ns/1ps
// jcb_nway -- N-channel clocked confluence buffer.
//
// Merges N single-pulse input channels onto one output pulse line. A rising
// edge on a channel is an event. An event is rejected when any other channel
// had an event within GUARD edges. Simultaneous events are all dropped
// (MODE 0) or resolved to the lowest eligible index (MODE 1). Each accepted
// event reappears on dout DELAY edges later as a PW-cycle pulse.
// Overlapping or abutting pulses merge into one continuous high.
//
// Ports
//   clk           single clock, all state on the rising edge
//   rst           synchronous active-high reset
//   din[N]        per-channel pulse inputs (event = 0->1 transition)
//   dout          merged output pulse, registered
//   accepted_cnt  saturating count of accepted events
//   dropped_cnt   saturating count of rejected events
//   last_src      index of the most recently accepted channel
module jcb_nway #(
  parameter int N     = 2,
  parameter int DELAY = 8,
  parameter int PW    = 2,
  parameter int GUARD = 5,
  parameter int MODE  = 0,
  parameter int CW    = 8,
  localparam int LW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  din,
  output logic          dout,
  output logic [CW-1:0] accepted_cnt,
  output logic [CW-1:0] dropped_cnt,
  output logic [LW-1:0] last_src
);

  localparam int TW = $clog2(GUARD + 2);
  localparam int WW = $clog2(PW + 1);
  localparam int NW = $clog2(N + 1);
  localparam logic [TW-1:0] TS_SAT   = TW'(GUARD + 1);
  localparam logic [TW-1:0] TS_GUARD = TW'(GUARD);

  // Counter add that clamps at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a,
                                            input logic [NW-1:0] b);
    logic [CW+NW-1:0] s;
    s = {{NW{1'b0}}, a} + {{CW{1'b0}}, b};
    if (s > {{NW{1'b0}}, {CW{1'b1}}}) return '1;
    return s[CW-1:0];
  endfunction

  logic [N-1:0]     din_q;
  logic [N-1:0]     ev;
  logic [N-1:0]     elig;
  logic [N-1:0]     acc_vec;
  logic             acc_any;
  logic             pick_done;
  logic [LW-1:0]    acc_idx;
  logic [NW-1:0]    n_ev;
  logic [NW-1:0]    n_drop;

  // ts_q[i] holds the distance (in edges) from the current edge back to the
  // last event on channel i, clamped at GUARD+1 which means "no recent event".
  logic [TW-1:0]    ts_q [N];
  logic [TW-1:0]    ts_d [N];

  logic [DELAY-1:0] dly_q, dly_d;
  logic [WW-1:0]    wcnt_q, wcnt_d;
  logic             dout_q;
  logic [CW-1:0]    acc_cnt_q, drop_cnt_q;
  logic [LW-1:0]    src_q;

  // Event detection and accept/drop decision
  always_comb begin
    ev        = din & ~din_q;
    elig      = '1;
    n_ev      = '0;
    acc_vec   = '0;
    acc_idx   = '0;
    pick_done = 1'b0;
    for (int i = 0; i < N; i++) begin
      n_ev = n_ev + NW'(ev[i]);
      // Only other channels can block; a channel never blocks itself.
      for (int j = 0; j < N; j++) begin
        if (j != i && ts_q[j] <= TS_GUARD) elig[i] = 1'b0;
      end
    end
    if (MODE == 0) begin
      // Any simultaneous event kills every event at this edge.
      if (n_ev == NW'(1)) acc_vec = ev & elig;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ev[i] && elig[i] && !pick_done) begin
          acc_vec[i] = 1'b1;
          pick_done  = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc_vec[i]) acc_idx = LW'(i);
    end
    acc_any = |acc_vec;
    n_drop  = n_ev - NW'(acc_any);

    for (int i = 0; i < N; i++) begin
      if (ev[i])                 ts_d[i] = TW'(1);
      else if (ts_q[i] == TS_SAT) ts_d[i] = ts_q[i];
      else                       ts_d[i] = ts_q[i] + TW'(1);
    end
  end

  // Output path: delay line feeding a reloadable width counter
  always_comb begin
    dly_d = (dly_q << 1) | DELAY'(acc_any);
    if (dly_q[DELAY-1])       wcnt_d = WW'(PW);
    else if (wcnt_q != '0)    wcnt_d = wcnt_q - WW'(1);
    else                      wcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    // din_q follows din even in reset so a level held across release is
    // not mistaken for a new edge.
    din_q <= din;
    if (rst) begin
      for (int i = 0; i < N; i++) ts_q[i] <= TS_SAT;
      dly_q      <= '0;
      wcnt_q     <= '0;
      dout_q     <= 1'b0;
      acc_cnt_q  <= '0;
      drop_cnt_q <= '0;
      src_q      <= '0;
    end else begin
      for (int i = 0; i < N; i++) ts_q[i] <= ts_d[i];
      dly_q      <= dly_d;
      wcnt_q     <= wcnt_d;
      dout_q     <= (wcnt_d != '0);
      acc_cnt_q  <= sat_add(acc_cnt_q, NW'(acc_any));
      drop_cnt_q <= sat_add(drop_cnt_q, n_drop);
      if (acc_any) src_q <= acc_idx;
    end
  end

  assign dout         = dout_q;
  assign accepted_cnt = acc_cnt_q;
  assign dropped_cnt  = drop_cnt_q;
  assign last_src     = src_q;

endmodule
